// File: rtl/fp16_mac_pkg.sv
// Shared types and defaults for the FP16 multiply-accumulate sequencer and datapath.
package fp16_mac_pkg;

    localparam int DEF_PIPE_DEPTH = 2;
    localparam int DEF_LEN_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp16_mac_vpipe.sv
// Valid-bit shift register mirroring the fixed multiply/normalize latency.
module fp16_mac_vpipe
    import fp16_mac_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = '0;
        if (!clr) begin
            pipe_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fp16_mac_seq.sv
// Control sequencer for the FP16 dot-product MAC: gates operand issue, tracks
// products through the fixed-latency pipe and drives the accumulator strobes.
module fp16_mac_seq
    import fp16_mac_pkg::*;
#(
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             issue,
    output logic             acc_en,
    output logic             acc_first,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             err,
    output logic [LEN_W-1:0] acc_cnt
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             err_q, err_d;
    logic             handshake;
    logic             last_issue;
    logic             last_retire;
    logic             pipe_out;

    assign in_ready     = (state_q == ST_RUN);
    assign handshake    = in_valid & in_ready;
    assign issue        = handshake;
    assign acc_en       = pipe_out;
    assign acc_first    = pipe_out & (acc_cnt_q == '0);
    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign err          = err_q;
    assign acc_cnt      = acc_cnt_q;

    // Comparing against len-1 keeps a full-scale job from needing a wider counter.
    assign last_issue  = handshake & (issued_q == len_q - LEN_W'(1));
    assign last_retire = acc_en & (acc_cnt_q == len_q - LEN_W'(1));

    fp16_mac_vpipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_vpipe (
        .clk (clk),
        .rst (rst),
        .clr (abort),
        .din (handshake),
        .dout(pipe_out)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q;
        acc_cnt_d = acc_cnt_q;
        err_d     = 1'b0;

        if (handshake) begin
            issued_d = issued_q + LEN_W'(1);
        end
        if (acc_en) begin
            acc_cnt_d = acc_cnt_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = len;
                        issued_d  = '0;
                        acc_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (last_retire) begin
                    state_d = ST_DONE;
                end else if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_retire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides any handshake or retirement in flight.
        if (abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            issued_d  = '0;
            acc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            acc_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            acc_cnt_q <= acc_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fp16_mac_seq.sv
// Scoreboard bench for fp16_mac_seq: stimulus pushes expected accumulator,
// error and result events; a negedge monitor pops and compares them.
module tb_fp16_mac_seq;

    localparam int D  = 2;
    localparam int LW = 8;

    localparam int EV_ACC  = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic        first;
        logic [LW-1:0] cnt;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          result_ready = 1'b0;
    logic          in_ready;
    logic          issue;
    logic          acc_en;
    logic          acc_first;
    logic          result_valid;
    logic          busy;
    logic          err;
    logic [LW-1:0] acc_cnt;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    ev_t sb[$];

    fp16_mac_seq #(
        .PIPE_DEPTH(D),
        .LEN_W     (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .issue       (issue),
        .acc_en      (acc_en),
        .acc_first   (acc_first),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .err         (err),
        .acc_cnt     (acc_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input logic first, input logic [LW-1:0] cnt);
        ev_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.first = first;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic first, input logic [LW-1:0] cnt);
        ev_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_event: got kind %0d expected no event (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            check_output("ev_kind", kind, e.kind);
            check_output("ev_cycle", cyc, e.cyc);
            if (e.kind == EV_ACC) begin
                check_output("ev_acc_first", {31'd0, first}, {31'd0, e.first});
            end
            if (e.kind != EV_ERR) begin
                check_output("ev_acc_cnt", {24'd0, cnt}, {24'd0, e.cnt});
            end
        end
    endtask

    // Monitor: every DUT-presented event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (acc_en) pop_check(EV_ACC, acc_first, acc_cnt);
            if (err) pop_check(EV_ERR, 1'b0, acc_cnt);
            if (result_valid && result_ready) pop_check(EV_DONE, 1'b0, acc_cnt);
        end
    end

    task automatic apply_stimulus(input int n, input logic [31:0] pattern, input int ready_delay, input bit pulse_start);
        int issued;
        int last;
        int done_cyc;
        int i;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = LW'(1);
        check_output("run_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("run_busy", {31'd0, busy}, 32'd1);
        issued = 0;
        i      = 0;
        last   = cyc;
        while (issued < n && i < 600) begin
            in_valid = pattern[i % 32];
            #1;
            check_output("issue", {31'd0, issue}, {31'd0, in_valid});
            if (in_valid) begin
                expect_ev(EV_ACC, cyc + D, (issued == 0), LW'(issued));
                issued++;
                last = cyc;
            end
            @(posedge clk); #1;
            i++;
        end
        in_valid = 1'b0;
        check_output("drain_in_ready", {31'd0, in_ready}, 32'd0);
        done_cyc = last + D + 1;
        while (cyc < done_cyc + ready_delay) begin
            check_output("result_valid", {31'd0, result_valid}, {31'd0, (cyc >= done_cyc)});
            if (pulse_start) begin
                start = (cyc % 2 == 0);
                len   = LW'(7);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_output("result_valid_final", {31'd0, result_valid}, 32'd1);
        result_ready = 1'b1;
        expect_ev(EV_DONE, cyc, 1'b0, LW'(n));
        @(posedge clk); #1;
        result_ready = 1'b0;
        check_output("idle_busy", {31'd0, busy}, 32'd0);
        check_output("idle_result_valid", {31'd0, result_valid}, 32'd0);
        check_output("idle_acc_cnt", {24'd0, acc_cnt}, n);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int abort_cyc;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_outputs",
                     {17'd0, in_ready, issue, acc_en, acc_first, result_valid, busy, err, acc_cnt}, 32'd0);
        rst = 1'b0;

        apply_stimulus(4, 32'hFFFF_FFFF, 0, 1'b0);
        apply_stimulus(3, 32'b10101, 0, 1'b0);

        // Zero-length request: one error pulse, no job.
        @(posedge clk); #1;
        start    = 1'b1;
        len      = '0;
        in_valid = 1'b1;
        expect_ev(EV_ERR, cyc + 1, 1'b0, '0);
        @(posedge clk); #1;
        start = 1'b0;
        check_output("err_pulse", {31'd0, err}, 32'd1);
        check_output("err_busy", {31'd0, busy}, 32'd0);
        check_output("err_issue", {31'd0, issue}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_output("err_one_cycle", {31'd0, err}, 32'd0);

        apply_stimulus(2, 32'hFFFF_FFFF, 5, 1'b1);

        // Abort coinciding with the third handshake.
        @(posedge clk); #1;
        start = 1'b1;
        len   = LW'(5);
        @(posedge clk); #1;
        start     = 1'b0;
        abort_cyc = cyc + 2;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            if (k == 2) abort = 1'b1;
            if (cyc + D <= abort_cyc) expect_ev(EV_ACC, cyc + D, (k == 0), LW'(k));
            @(posedge clk); #1;
        end
        abort    = 1'b0;
        in_valid = 1'b0;
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check_output("abort_acc_cnt", {24'd0, acc_cnt}, 32'd0);
        check_output("abort_acc_en", {31'd0, acc_en}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_output("abort_quiet_cnt", {24'd0, acc_cnt}, 32'd0);
        check_output("abort_quiet_rv", {31'd0, result_valid}, 32'd0);

        // Asynchronous reset in the middle of a job.
        @(posedge clk); #1;
        start = 1'b1;
        len   = LW'(4);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_output("rst_async",
                     {17'd0, in_ready, issue, acc_en, acc_first, result_valid, busy, err, acc_cnt}, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        apply_stimulus(1, 32'hFFFF_FFFF, 0, 1'b0);
        apply_stimulus(255, 32'hFFFF_FFFF, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check_output("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
